// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//   Two-entry in-order FIFO sitting between the fetch and decode stages.
//   Fetch pushes {pc, instruction} pairs while in_ready is high; decode pops the
//   head entry while out_valid is high. A flush (taken branch further down the
//   pipe) empties the buffer and discards any word offered in the same cycle.
//
//   Optional feature macro: IF_ID_BUFFER_STATS_EN
//     When defined, adds the saturating statistics outputs flush_drop_count and
//     stall_cycles. When undefined, those ports and their logic do not exist.
//
// Ports
//   clk              rising-edge clock for all state
//   rst              synchronous active-high reset
//   flush            discard all buffered and incoming fetches
//   in_valid         fetch stage presents an instruction
//   in_pc            PC+1 value from fetch
//   in_instruction   fetched instruction word
//   in_ready         buffer can accept a push (low freezes fetch)
//   out_valid        head entry valid for decode
//   out_pc           PC of head entry (0 when out_valid is low)
//   out_instruction  instruction of head entry (0 when out_valid is low)
//   out_ready        decode consumes the head this cycle
//   count            number of valid entries, 0..2
//   flush_drop_count (stats only) entries discarded by flushes, saturating
//   stall_cycles     (stats only) cycles with in_valid high and in_ready low
// -----------------------------------------------------------------------------
module if_id_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instruction,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instruction,
   input  logic        out_ready,
   output logic [1:0]  count
`ifdef IF_ID_BUFFER_STATS_EN
   ,
   output logic [15:0] flush_drop_count,
   output logic [15:0] stall_cycles
`endif
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [31:0] pc_mem    [2];
   logic [31:0] instr_mem [2];
   logic        push;
   logic        pop;

   // Handshake signals come from registered state only, so there is no
   // combinational path from the input side to the output side.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign count     = state_q;

   assign push = in_valid  & in_ready;
   assign pop  = out_valid & out_ready;

   assign out_pc          = out_valid ? pc_mem[rd_ptr]    : 32'd0;
   assign out_instruction = out_valid ? instr_mem[rd_ptr] : 32'd0;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
               if (push && !pop)      state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   // With one entry held, rd_ptr + 1 == wr_ptr, so a simultaneous push/pop
   // naturally makes the newly written word the next head.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         pc_mem[0]    <= 32'd0;
         pc_mem[1]    <= 32'd0;
         instr_mem[0] <= 32'd0;
         instr_mem[1] <= 32'd0;
      end else begin
         state_q <= state_d;
         if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
         end else begin
            if (push) begin
               pc_mem[wr_ptr]    <= in_pc;
               instr_mem[wr_ptr] <= in_instruction;
               wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
         end
      end
   end

`ifdef IF_ID_BUFFER_STATS_EN
   function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                             input logic [2:0]  b);
      logic [16:0] sum;
      sum = {1'b0, a} + {14'd0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic [2:0] drop_n;

   // Entries lost to a flush: everything held plus the word offered this cycle.
   assign drop_n = {1'b0, count} + {2'd0, in_valid};

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_drop_count <= 16'd0;
         stall_cycles     <= 16'd0;
      end else begin
         if (flush) begin
            flush_drop_count <= sat_add16(flush_drop_count, drop_n);
         end
         if (in_valid && !in_ready) begin
            stall_cycles <= sat_add16(stall_cycles, 3'd1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instruction;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;
   logic        out_ready;
   logic [1:0]  count;
`ifdef IF_ID_BUFFER_STATS_EN
   logic [15:0] flush_drop_count;
   logic [15:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   if_id_buffer dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_pc           (in_pc),
      .in_instruction  (in_instruction),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_pc          (out_pc),
      .out_instruction (out_instruction),
      .out_ready       (out_ready),
      .count           (count)
`ifdef IF_ID_BUFFER_STATS_EN
      ,
      .flush_drop_count(flush_drop_count),
      .stall_cycles    (stall_cycles)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t      sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [15:0] m_fdc   = 16'd0;
   logic [15:0] m_stall = 16'd0;

   function automatic logic [15:0] sat16(input logic [15:0] a, input int b);
      int s;
      s = int'(a) + b;
      return (s > 65535) ? 16'hFFFF : s[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: whenever decode takes the head, compare it against the oldest
   // expected entry.
   always @(negedge clk) begin
      entry_t e;
      if (mon_en && rst === 1'b0 && flush === 1'b0) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL pop_unexpected: got pc %0h expected no entry", out_pc);
            end else begin
               e = sb_q.pop_front();
               chk("head_pc", out_pc, e.pc);
               chk("head_instr", out_instruction, e.ins);
            end
         end else if (out_valid === 1'b0) begin
            chk("idle_pc", out_pc, 32'd0);
            chk("idle_instr", out_instruction, 32'd0);
         end
      end
   end

   // One clock of stimulus; the reference model is an ordinary queue of at
   // most two entries. Called at time 0 or 1 time unit after a rising edge.
   task automatic step(input bit r, input bit f, input bit iv,
                       input logic [31:0] pc, input logic [31:0] ins, input bit ordy);
      int     sz0;
      int     sz;
      bit     acc;
      entry_t e;
      rst            = r;
      flush          = f;
      in_valid       = iv;
      in_pc          = pc;
      in_instruction = ins;
      out_ready      = ordy;
      sz0 = sb_q.size();
      acc = iv && !r && !f && (sz0 < 2);
      @(posedge clk);
      #1;
      if (r || f) begin
         sb_q.delete();
      end else if (acc) begin
         e.pc  = pc;
         e.ins = ins;
         sb_q.push_back(e);
      end
      if (r) begin
         m_fdc   = 16'd0;
         m_stall = 16'd0;
      end else begin
         if (f) m_fdc = sat16(m_fdc, sz0 + int'(iv));
         if (iv && sz0 == 2) m_stall = sat16(m_stall, 1);
      end
      if (r) mon_en = 1'b1;
      if (mon_en) begin
         sz = sb_q.size();
         chk("count", 32'(count), 32'(sz));
         chk("out_valid", 32'(out_valid), 32'(sz != 0));
         chk("in_ready", 32'(in_ready), 32'(sz < 2));
         if (sz == 0) begin
            chk("empty_pc", out_pc, 32'd0);
            chk("empty_instr", out_instruction, 32'd0);
         end else begin
            chk("cur_head_pc", out_pc, sb_q[0].pc);
            chk("cur_head_instr", out_instruction, sb_q[0].ins);
         end
`ifdef IF_ID_BUFFER_STATS_EN
         chk("flush_drop_count", 32'(flush_drop_count), 32'(m_fdc));
         chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
      end
   endtask

   initial begin
      // Reset for two cycles while fetch keeps offering a word.
      step(1, 0, 1, 32'h55, 32'hAA, 0);
      step(1, 0, 1, 32'h56, 32'hAB, 0);
      chk("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
      chk("rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);

      // Single pass-through.
      step(0, 0, 1, 32'd1, 32'hE3A00005, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);

      // Fill to FULL; third push must be refused, then drain in order.
      step(0, 0, 1, 32'd1, 32'h1001, 0);
      step(0, 0, 1, 32'd2, 32'h1002, 0);
      step(0, 0, 1, 32'd3, 32'h1003, 0);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);

      // Streaming through ONE with a push and a pop every cycle.
      for (int i = 1; i <= 10; i++) step(0, 0, 1, 32'(i), 32'(32'h2000 + i), 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);

      // Flush in FULL with a concurrent push.
      step(0, 0, 1, 32'd21, 32'h3001, 0);
      step(0, 0, 1, 32'd22, 32'h3002, 0);
      step(0, 1, 1, 32'd23, 32'h3003, 0);
`ifdef IF_ID_BUFFER_STATS_EN
      chk("flush_drop_full", 32'(flush_drop_count), 32'd3);
`endif
      step(0, 0, 0, 32'd0, 32'd0, 1);

      // Reset in FULL together with flush, pop and push.
      step(0, 0, 1, 32'd31, 32'h4001, 0);
      step(0, 0, 1, 32'd32, 32'h4002, 0);
      step(1, 1, 1, 32'd33, 32'h4003, 1);
      chk("rst_full_wr_ptr", 32'(dut.wr_ptr), 32'd0);
      chk("rst_full_rd_ptr", 32'(dut.rd_ptr), 32'd0);

      // Randomized traffic with occasional flushes and resets.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
              ($urandom_range(0, 99) < 70), $urandom, $urandom,
              ($urandom_range(0, 99) < 55));
      end
      step(0, 0, 0, 32'd0, 32'd0, 1);
      step(0, 0, 0, 32'd0, 32'd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
